// File: rtl/bus_master.sv
// Burst initiator for the shared memory-mapped bus: fill writes and streamed reads.
// One bus beat per cycle; all state frozen while the PLL is unlocked.
module bus_master #(
    parameter int unsigned ABITS = 32,
    parameter int unsigned DBITS = 32,
    parameter int unsigned CBITS = 8,
    parameter int unsigned ASTEP = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             LOCK,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_WR,
    input  logic [ABITS-1:0] CMD_ADDR,
    input  logic [DBITS-1:0] CMD_DATA,
    input  logic [CBITS-1:0] CMD_CNT,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [DBITS-1:0] RSP_DATA,
    output logic             RSP_LAST,
    output logic             DONE,
    output logic             BUSY,
    output logic [ABITS-1:0] ABUS,
    output logic [DBITS-1:0] WBUS,
    output logic             RE,
    output logic             WE,
    input  logic [DBITS-1:0] RBUS
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DRAIN} state_e;

    state_e             state_q, state_d;
    logic [ABITS-1:0]   abus_q, abus_d;
    logic [DBITS-1:0]   wbus_q, wbus_d;
    logic [CBITS-1:0]   rem_q, rem_d;
    logic [DBITS-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_last_q, rsp_last_d;
    logic               done_q, done_d;
    logic               take;

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
        end else if (LOCK) begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            abus_q      <= '0;
            wbus_q      <= '0;
            rem_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else if (LOCK) begin
            abus_q      <= abus_d;
            wbus_q      <= wbus_d;
            rem_q       <= rem_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            done_q      <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        abus_d      = abus_q;
        wbus_d      = wbus_q;
        rem_d       = rem_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        done_d      = 1'b0;
        take        = rsp_valid_q && RSP_READY;

        if (take) begin
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    abus_d  = CMD_ADDR;
                    wbus_d  = CMD_DATA;
                    rem_d   = CMD_CNT;
                    state_d = CMD_WR ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if (WE) begin
                    abus_d = abus_q + ABITS'(ASTEP);
                    rem_d  = rem_q - CBITS'(1);
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                // A refill on the same edge as a take overrides the clear above
                if (RE) begin
                    rsp_data_d  = RBUS;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (rem_q == '0);
                    abus_d      = abus_q + ABITS'(ASTEP);
                    rem_d       = rem_q - CBITS'(1);
                    if (rem_q == '0) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (take) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; strobes and ready are gated by LOCK combinationally
    always_comb begin
        CMD_READY = (state_q == S_IDLE) && LOCK;
        WE        = (state_q == S_WR) && LOCK;
        RE        = (state_q == S_RD) && LOCK && (!rsp_valid_q || RSP_READY);
        BUSY      = (state_q != S_IDLE);
        DONE      = done_q;
        ABUS      = abus_q;
        WBUS      = wbus_q;
        RSP_VALID = rsp_valid_q;
        RSP_DATA  = rsp_data_q;
        RSP_LAST  = rsp_last_q;
    end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: vector table of bursts plus reset and lock sequences.
// A small word memory and a read-clear key register sit on the bus.
module tb_bus_master;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  cnt;
        int          mode;       // 0: RSP_READY held 1, 1: pattern 1,0,0,1
        int          lock_at;    // cycle at which LOCK drops for 3 cycles, 0 = never
        logic [31:0] exp_data;
        int          exp_beats;
        logic [31:0] exp_last_addr;
        int          exp_key;
    } vec_t;

    localparam logic [31:0] KEY_ADDR = 32'h0000_01FC;
    localparam logic [31:0] KEY_VAL  = 32'h0000_004B;

    logic        clk, rstn, lock;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_data;
    logic [7:0]  cmd_cnt;
    logic        rsp_valid, rsp_ready, rsp_last;
    logic [31:0] rsp_data;
    logic        done, busy, re, we;
    logic [31:0] abus, wbus, rbus;
    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs [8];

    bus_master #(.ABITS(32), .DBITS(32), .CBITS(8), .ASTEP(4)) dut (
        .CLK(clk), .RSTN(rstn), .LOCK(lock),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WR(cmd_wr),
        .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .CMD_CNT(cmd_cnt),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
        .RSP_LAST(rsp_last), .DONE(done), .BUSY(busy),
        .ABUS(abus), .WBUS(wbus), .RE(re), .WE(we), .RBUS(rbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rbus = (abus == KEY_ADDR) ? KEY_VAL : mem[abus[9:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int c);
        lock      = !(v.lock_at != 0 && c >= v.lock_at && c < v.lock_at + 3);
        rsp_ready = (v.mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] baddr[$];
        logic [31:0] bdata[$];
        logic [31:0] rdata[$];
        logic        rlast[$];
        logic [31:0] frz = '0;
        bit          frz_ok = 0;
        bit          got_done = 0;
        int          done_cnt = 0, busy_cyc = 0, first_valid = -1, keys = 0, cyc = 0;

        @(negedge clk);
        cmd_wr = v.wr; cmd_addr = v.addr; cmd_data = v.data; cmd_cnt = v.cnt;
        cmd_valid = 1'b1;
        chk({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_wr = ~v.wr; cmd_addr = 32'hDEAD_0000; cmd_data = 32'h5555_AAAA; cmd_cnt = 8'hFF;
        drive(v, 0);
        while (!got_done && cyc < 300) begin
            @(negedge clk);
            if (we) begin
                baddr.push_back(abus);
                bdata.push_back(wbus);
                mem[abus[9:2]] = wbus;
            end
            if (re) begin
                baddr.push_back(abus);
                if (abus == KEY_ADDR) keys++;
            end
            if (rsp_valid && rsp_ready) begin
                rdata.push_back(rsp_data);
                rlast.push_back(rsp_last);
            end
            if (busy) busy_cyc++;
            if (rsp_valid && first_valid < 0) first_valid = cyc;
            if (cyc == 0) chk({tag, " cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
            if (!lock) begin
                chk({tag, " strobes_unlocked"}, 32'({re, we}), 32'd0);
                if (!frz_ok) begin frz = abus; frz_ok = 1; end
                else chk({tag, " abus_frozen"}, abus, frz);
            end
            if (done) begin
                got_done = 1;
                done_cnt++;
                chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
                chk({tag, " ready_in_done"}, 32'(cmd_ready), 32'd1);
            end else begin
                @(posedge clk); #1;
                cyc++;
                drive(v, cyc);
            end
        end
        chk({tag, " done_seen"}, 32'(got_done), 32'd1);
        @(negedge clk);
        if (done) done_cnt++;
        chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, " beats"}, 32'(baddr.size()), 32'(v.exp_beats));
        for (int i = 0; i < baddr.size(); i++)
            chk({tag, $sformatf(" addr%0d", i)}, baddr[i], v.addr + 32'(4 * i));
        if (baddr.size() > 0)
            chk({tag, " last_addr"}, baddr[baddr.size() - 1], v.exp_last_addr);
        chk({tag, " key_clears"}, 32'(keys), 32'(v.exp_key));
        if (v.wr) begin
            for (int i = 0; i < bdata.size(); i++)
                chk({tag, $sformatf(" wdata%0d", i)}, bdata[i], v.data);
            chk({tag, " mem_last"}, mem[v.exp_last_addr[9:2]], v.data);
            if (v.lock_at == 0) chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'(v.exp_beats));
        end else begin
            chk({tag, " rsp_beats"}, 32'(rdata.size()), 32'(v.exp_beats));
            for (int i = 0; i < rdata.size(); i++) begin
                chk({tag, $sformatf(" rdata%0d", i)}, rdata[i], v.exp_data);
                chk({tag, $sformatf(" rlast%0d", i)}, 32'(rlast[i]), 32'(i == v.exp_beats - 1));
            end
            if (v.mode == 0 && v.lock_at == 0) begin
                chk({tag, " first_valid_cyc"}, 32'(first_valid), 32'd1);
                chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'(v.exp_beats + 1));
            end
        end
        lock = 1'b1;
        rsp_ready = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " re"}, 32'(re), 32'd0);
        chk({tag, " we"}, 32'(we), 32'd0);
        chk({tag, " abus"}, abus, 32'd0);
        chk({tag, " wbus"}, wbus, 32'd0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_last"}, 32'(rsp_last), 32'd0);
        chk({tag, " rsp_data"}, rsp_data, 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; lock = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_cnt = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        //         wr    addr           data           cnt  md lk exp_data       beats last_addr      key
        vecs[0] = '{1'b1, 32'h0000_0100, 32'h0000_BEEF, 8'd3, 0, 0, 32'h0,         4, 32'h0000_010C, 0};
        vecs[1] = '{1'b0, 32'h0000_0100, 32'h0,         8'd2, 0, 0, 32'h0000_BEEF, 3, 32'h0000_0108, 0};
        vecs[2] = '{1'b0, 32'h0000_0100, 32'h0,         8'd3, 1, 0, 32'h0000_BEEF, 4, 32'h0000_010C, 0};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_1234, 8'd1, 0, 0, 32'h0,         2, 32'h0000_0000, 0};
        vecs[4] = '{1'b1, 32'h0000_01F8, 32'h0000_004B, 8'd0, 0, 0, 32'h0,         1, 32'h0000_01F8, 0};
        vecs[5] = '{1'b0, 32'h0000_01F8, 32'h0,         8'd1, 1, 0, 32'h0000_004B, 2, 32'h0000_01FC, 1};
        vecs[6] = '{1'b1, 32'h0000_0300, 32'h0000_0077, 8'd4, 0, 2, 32'h0,         5, 32'h0000_0310, 0};
        vecs[7] = '{1'b0, 32'h0000_0300, 32'h0,         8'd4, 0, 0, 32'h0000_0077, 5, 32'h0000_0310, 0};

        #12;
        chk_all_zero("reset");
        chk("reset cmd_ready_unlocked", 32'(cmd_ready), 32'd0);
        lock = 1'b1;
        #1;
        chk("reset cmd_ready_locked", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset asserted while the second beat of a 4-beat read is on the bus
        @(negedge clk);
        cmd_wr = 1'b0; cmd_addr = 32'h0000_0100; cmd_cnt = 8'd3; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst rsp_valid_before", 32'(rsp_valid), 32'd1);
        chk("midrst re_before", 32'(re), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        chk_all_zero("midrst_held");
        rstn = 1'b1;
        run_vec(vecs[1], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
